// File: rtl/register_file_pkg.sv
// Shared types and constant helpers for the multi-port register file with flush.
package register_file_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } flush_state_e;

   // ceil(log2(value)), 0 for value <= 1; usable in parameter expressions
   function automatic int clog2_f(input int value);
      int result;
      int rem;
      result = 32'sd0;
      rem    = value - 32'sd1;
      while (rem > 32'sd0) begin
         rem    = rem >>> 32'sd1;
         result = result + 32'sd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/register_file_flush_ctrl.sv
// Flush sequencer: walks the array one group of FLUSH_WORDS words per cycle and
// raises a one-hot clear strobe for the group being zeroed.
module register_file_flush_ctrl
   import register_file_pkg::*;
#(
   parameter  int ADDR_WIDTH  = 5,
   parameter  int FLUSH_WORDS = 4,
   localparam int NUM_GROUPS  = (2 ** ADDR_WIDTH) / FLUSH_WORDS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_req_i,
   output logic                  idle_o,
   output logic                  flush_busy_o,
   output logic                  flush_done_o,
   output logic [NUM_GROUPS-1:0] clear_grp_o
);

   localparam int GRP_BITS = ADDR_WIDTH - clog2_f(FLUSH_WORDS);
   // A single-group array still needs a 1-bit counter to stay legal
   localparam int CNT_W = (GRP_BITS > 0) ? GRP_BITS : 1;
   localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_GROUPS - 1);

   flush_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   // Next-state, group counter and completion pulse
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (flush_req_i) begin
               state_d = FLUSH;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
               cnt_d   = cnt_q;
            end
         end
         FLUSH: begin
            if (cnt_q == LAST_GRP) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               state_d = FLUSH;
               cnt_d   = cnt_q + CNT_W'(32'd1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Per-group clear strobe decoded from the current group counter
   always_comb begin
      clear_grp_o = '0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
         clear_grp_o[g] = (state_q == FLUSH) && (cnt_q == CNT_W'(g));
      end
   end

   // State, counter and done-pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign idle_o       = (state_q == IDLE);
   assign flush_busy_o = (state_q == FLUSH);
   assign flush_done_o = done_q;

endmodule

// File: rtl/register_file_multi_port_flush_ff.sv
// Flip-flop register file: N_READ registered-address read ports, N_WRITE
// byte-enabled write ports with lowest-port-wins per byte, and a grouped flush.
module register_file_multi_port_flush_ff
   import register_file_pkg::*;
#(
   parameter  int ADDR_WIDTH  = 5,
   parameter  int DATA_WIDTH  = 32,
   parameter  int N_READ      = 2,
   parameter  int N_WRITE     = 2,
   parameter  int FLUSH_WORDS = 4,
   localparam int BE_WIDTH    = DATA_WIDTH / 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 test_en_i,
   input  logic [N_READ-1:0]                    ReadEnable,
   input  logic [N_READ-1:0][ADDR_WIDTH-1:0]    ReadAddr,
   output logic [N_READ-1:0][DATA_WIDTH-1:0]    ReadData,
   input  logic [N_WRITE-1:0]                   WriteEnable,
   input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]   WriteAddr,
   input  logic [N_WRITE-1:0][BE_WIDTH-1:0]     WriteBE,
   input  logic [N_WRITE-1:0][DATA_WIDTH-1:0]   WriteData,
   output logic [N_WRITE-1:0]                   WriteGnt,
   input  logic                                 FlushReq,
   output logic                                 FlushBusy,
   output logic                                 FlushDone
);

   localparam int NUM_WORDS  = 2 ** ADDR_WIDTH;
   localparam int NUM_GROUPS = NUM_WORDS / FLUSH_WORDS;

   logic [DATA_WIDTH-1:0]             mem_q [NUM_WORDS];
   logic [DATA_WIDTH-1:0]             mem_d [NUM_WORDS];
   logic [N_READ-1:0][ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [NUM_GROUPS-1:0]             clear_grp_s;
   logic [NUM_WORDS-1:0]              clear_word_s;
   logic                              flush_idle_s;
   logic [7:0]                        byte_s;
   logic                              unused_test_en_s;

   // Reserved for a future clock-gate bypass
   assign unused_test_en_s = test_en_i;

   register_file_flush_ctrl #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .FLUSH_WORDS (FLUSH_WORDS)
   ) u_flush_ctrl (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_req_i  (FlushReq),
      .idle_o       (flush_idle_s),
      .flush_busy_o (FlushBusy),
      .flush_done_o (FlushDone),
      .clear_grp_o  (clear_grp_s)
   );

   assign WriteGnt = WriteEnable & {N_WRITE{flush_idle_s}};

   // Expand group strobes to per-word clear enables
   always_comb begin
      clear_word_s = '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         clear_word_s[i] = clear_grp_s[i / FLUSH_WORDS];
      end
   end

   // Byte-wise array update; ports scanned high to low so the lowest granted
   // port that enables a byte has the final say on it
   always_comb begin
      byte_s = 8'h00;
      for (int i = 0; i < NUM_WORDS; i++) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            byte_s = mem_q[i][b*8 +: 8];
            for (int w = N_WRITE - 1; w >= 0; w--) begin
               byte_s = (WriteGnt[w] && WriteBE[w][b] && (WriteAddr[w] == ADDR_WIDTH'(i)))
                        ? WriteData[w][b*8 +: 8] : byte_s;
            end
            mem_d[i][b*8 +: 8] = clear_word_s[i] ? 8'h00 : byte_s;
         end
      end
   end

   // Read address capture
   always_comb begin
      raddr_d = raddr_q;
      for (int z = 0; z < N_READ; z++) begin
         raddr_d[z] = ReadEnable[z] ? ReadAddr[z] : raddr_q[z];
      end
   end

   // Read data follows the array at the captured address
   always_comb begin
      ReadData = '0;
      for (int z = 0; z < N_READ; z++) begin
         ReadData[z] = mem_q[raddr_q[z]];
      end
   end

   // Array and read-address registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            mem_q[i] <= '0;
         end
         raddr_q <= '0;
      end else begin
         mem_q   <= mem_d;
         raddr_q <= raddr_d;
      end
   end

endmodule

// File: tb/tb_register_file_multi_port_flush_ff.sv
// Randomised scoreboard bench for register_file_multi_port_flush_ff against a
// word-array reference model.
module tb_register_file_multi_port_flush_ff;

   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int NR   = 2;
   localparam int NW   = 2;
   localparam int FW   = 4;
   localparam int BEW  = DW / 8;
   localparam int NWDS = 2 ** AW;
   localparam int NGRP = NWDS / FW;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   test_en_i;
   logic [NR-1:0]          re;
   logic [NR-1:0][AW-1:0]  ra;
   logic [NR-1:0][DW-1:0]  rd;
   logic [NW-1:0]          we;
   logic [NW-1:0][AW-1:0]  wa;
   logic [NW-1:0][BEW-1:0] wbe;
   logic [NW-1:0][DW-1:0]  wd;
   logic [NW-1:0]          gnt;
   logic                   fr;
   logic                   busy;
   logic                   done;

   typedef struct packed {
      logic [NR-1:0][DW-1:0] rd;
      logic [NW-1:0]         gnt;
      logic                  busy;
      logic                  done;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   logic [DW-1:0] m_mem   [NWDS];
   logic [AW-1:0] m_raddr [NR];
   int            flush_left = 0;
   bit            done_p     = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   register_file_multi_port_flush_ff #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .N_READ (NR), .N_WRITE (NW), .FLUSH_WORDS (FW)
   ) dut (
      .clk (clk), .rst_n (rst_n), .test_en_i (test_en_i),
      .ReadEnable (re), .ReadAddr (ra), .ReadData (rd),
      .WriteEnable (we), .WriteAddr (wa), .WriteBE (wbe), .WriteData (wd), .WriteGnt (gnt),
      .FlushReq (fr), .FlushBusy (busy), .FlushDone (done)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < NWDS; i++) m_mem[i] = '0;
      for (int z = 0; z < NR; z++) m_raddr[z] = '0;
      flush_left = 0;
      done_p     = 1'b0;
   endtask

   // Effect of one rising edge on the reference model
   task automatic model_edge();
      bit done_next;
      bit beaten;
      int base;
      done_next = (flush_left == 1);
      if (flush_left > 0) begin
         base = (NGRP - flush_left) * FW;
         for (int k = 0; k < FW; k++) m_mem[base + k] = '0;
         flush_left = flush_left - 1;
      end else begin
         for (int w = 0; w < NW; w++) begin
            for (int b = 0; b < BEW; b++) begin
               if (we[w] && wbe[w][b]) begin
                  beaten = 1'b0;
                  for (int v = 0; v < w; v++)
                     if (we[v] && wbe[v][b] && wa[v] == wa[w]) beaten = 1'b1;
                  if (!beaten) m_mem[wa[w]][b*8 +: 8] = wd[w][b*8 +: 8];
               end
            end
         end
         if (fr) flush_left = NGRP;
      end
      for (int z = 0; z < NR; z++) if (re[z]) m_raddr[z] = ra[z];
      done_p = done_next;
   endtask

   // Inputs for this cycle are already driven; queue what the DUT must show now
   task automatic step();
      exp_t e;
      if (!rst_n) model_reset();
      for (int z = 0; z < NR; z++) e.rd[z] = m_mem[m_raddr[z]];
      e.busy = (flush_left > 0);
      e.done = done_p;
      e.gnt  = e.busy ? '0 : we;
      exp_q.push_back(e);
      if (rst_n) model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      re = '0;
      we = '0;
      fr = 1'b0;
      for (int z = 0; z < NR; z++) ra[z] = AW'($urandom);
      for (int w = 0; w < NW; w++) begin
         wa[w]  = AW'($urandom);
         wbe[w] = BEW'($urandom);
         wd[w]  = $urandom;
      end
   endtask

   task automatic fill_all();
      for (int i = 0; i < NWDS / 2; i++) begin
         idle_inputs();
         we = 2'b11;
         wa[0] = AW'(i);
         wa[1] = AW'(i + NWDS / 2);
         wbe[0] = 4'hF;
         wbe[1] = 4'hF;
         wd[0] = $urandom | 32'h1;
         wd[1] = $urandom | 32'h1;
         step();
      end
   endtask

   // Monitor: DUT outputs are stable mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         for (int z = 0; z < NR; z++) begin
            n_vec++;
            if (rd[z] !== mon_e.rd[z]) begin
               n_err++;
               $display("FAIL ReadData[%0d] at %0t: got %h want %h", z, $time, rd[z], mon_e.rd[z]);
            end
         end
         n_vec++;
         if (gnt !== mon_e.gnt) begin
            n_err++;
            $display("FAIL WriteGnt at %0t: got %b want %b", $time, gnt, mon_e.gnt);
         end
         n_vec++;
         if (busy !== mon_e.busy) begin
            n_err++;
            $display("FAIL FlushBusy at %0t: got %b want %b", $time, busy, mon_e.busy);
         end
         n_vec++;
         if (done !== mon_e.done) begin
            n_err++;
            $display("FAIL FlushDone at %0t: got %b want %b", $time, done, mon_e.done);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      test_en_i = 1'b0;
      idle_inputs();
      @(posedge clk);
      #1;
      // Under reset: grants follow enables, nothing is written
      for (int i = 0; i < 2; i++) begin
         idle_inputs();
         we = 2'b11;
         step();
      end
      rst_n = 1'b1;
      idle_inputs();
      step();

      // Single write then read back
      idle_inputs();
      we = 2'b01; wa[0] = 5'd3; wbe[0] = 4'hF; wd[0] = 32'hA5A5_A5A5;
      step();
      idle_inputs(); re = 2'b01; ra[0] = 5'd3;
      step();
      idle_inputs();
      step();

      // Same-address byte conflict
      idle_inputs();
      we = 2'b11;
      wa[0] = 5'd7; wbe[0] = 4'h3; wd[0] = 32'h1111_1111;
      wa[1] = 5'd7; wbe[1] = 4'hE; wd[1] = 32'h2222_2222;
      step();
      idle_inputs(); re = 2'b10; ra[1] = 5'd7;
      step();
      idle_inputs();
      step();

      // Full flush with a held read on word 31 and a re-request mid-flush
      fill_all();
      idle_inputs(); re = 2'b11; ra[0] = 5'd31; ra[1] = 5'd5;
      step();
      idle_inputs(); fr = 1'b1;
      step();
      for (int c = 0; c < NGRP + 2; c++) begin
         idle_inputs();
         we = NW'($urandom);
         fr = (c == 3);
         step();
      end
      for (int i = 0; i < NWDS / 2; i++) begin
         idle_inputs(); re = 2'b11; ra[0] = AW'(i); ra[1] = AW'(i + NWDS / 2);
         step();
      end

      // Reset in the middle of a flush, then a fresh write
      fill_all();
      idle_inputs(); fr = 1'b1;
      step();
      for (int c = 0; c < 3; c++) begin
         idle_inputs();
         step();
      end
      rst_n = 1'b0;
      idle_inputs();
      step();
      rst_n = 1'b1;
      idle_inputs();
      we = 2'b01; wa[0] = 5'd0; wbe[0] = 4'hF; wd[0] = 32'hCAFE_0001;
      step();
      idle_inputs(); re = 2'b11; ra[0] = 5'd0; ra[1] = 5'd31;
      step();
      idle_inputs();
      step();

      // Flush request together with a write
      idle_inputs();
      fr = 1'b1; we = 2'b01; wa[0] = 5'd2; wbe[0] = 4'hF; wd[0] = 32'hDEAD_BEEF;
      step();
      idle_inputs(); re = 2'b01; ra[0] = 5'd2;
      step();
      for (int c = 0; c < NGRP + 1; c++) begin
         idle_inputs();
         step();
      end

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         idle_inputs();
         re = NR'($urandom);
         we = NW'($urandom);
         if ($urandom_range(0, 3) == 0) wa[1] = wa[0];
         fr = ($urandom_range(0, 39) == 0);
         step();
      end
      for (int c = 0; c < NGRP + 2; c++) begin
         idle_inputs();
         step();
      end

      @(negedge clk);
      #1;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/register_file_multi_port_flush_ff.md
REGISTER_FILE_MULTI_PORT_FLUSH_FF -- requirements
Module: register_file_multi_port_flush_ff

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, word address width; NUM_WORDS = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; must be a multiple of 8; BE_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter N_READ, default 2, number of read ports (>=1).
REQ-004 SHALL have parameter N_WRITE, default 2, number of write ports (>=1).
REQ-005 SHALL have parameter FLUSH_WORDS, default 4, words cleared per flush cycle; power of 2, <= NUM_WORDS.
REQ-006 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have test_en_i  input  1  test mode; no functional effect, reserved for clock-gate bypass.
REQ-009 SHALL have ReadEnable  input  [N_READ]  per-port read address capture.
REQ-010 SHALL have ReadAddr  input  [N_READ][ADDR_WIDTH]  read addresses.
REQ-011 SHALL have ReadData  output  [N_READ][DATA_WIDTH]  read data.
REQ-012 SHALL have WriteEnable  input  [N_WRITE]  per-port write request.
REQ-013 SHALL have WriteAddr  input  [N_WRITE][ADDR_WIDTH]  write addresses.
REQ-014 SHALL have WriteBE  input  [N_WRITE][BE_WIDTH]  byte enables.
REQ-015 SHALL have WriteData  input  [N_WRITE][DATA_WIDTH]  write data.
REQ-016 SHALL have WriteGnt  output  [N_WRITE]  write accepted this cycle.
REQ-017 SHALL have FlushReq  input  1  start clearing the whole array.
REQ-018 SHALL have FlushBusy  output  1  flush in progress.
REQ-019 SHALL have FlushDone  output  1  one-cycle pulse at flush completion.

Function
REQ-020 Read: ReadAddr[z] SHALL be registered when ReadEnable[z]=1; otherwise the registered address holds.
REQ-021 ReadData[z] SHALL combinationally show the array word at registered address z, so latency is 1 cycle and data tracks later writes to that address.
REQ-022 A write accepted in cycle N SHALL be visible on ReadData from cycle N+1.
REQ-023 WriteGnt[w] SHALL be WriteEnable[w] AND (FSM in IDLE); an ungranted write SHALL have no effect.
REQ-024 Granted writes SHALL update only the bytes whose WriteBE bit is set.
REQ-025 Same-address conflict: per byte, the lowest-index granted port with that BE bit set SHALL win; non-overlapping bytes from other ports SHALL still be written.
REQ-026 The flush FSM SHALL have the states IDLE and FLUSH, and a counter of width ADDR_WIDTH-log2(FLUSH_WORDS).
REQ-027 In IDLE with FlushReq=1: writes in that cycle SHALL still be granted, the FSM SHALL go to FLUSH with the counter at 0, and FlushBusy SHALL be high from the next cycle.
REQ-028 Each FLUSH cycle SHALL zero words counter*FLUSH_WORDS .. counter*FLUSH_WORDS+FLUSH_WORDS-1 and increment the counter.
REQ-029 On the last group the FSM SHALL return to IDLE, and FlushDone SHALL pulse for 1 cycle in the first IDLE cycle; a flush therefore takes NUM_WORDS/FLUSH_WORDS cycles.
REQ-030 FlushReq while in FLUSH SHALL be ignored.
REQ-031 Reads SHALL remain operational during FLUSH and return current (partially cleared) content.
REQ-032 FlushBusy SHALL equal (state == FLUSH).

Reset
REQ-033 Asserting rst_n=0 SHALL, asynchronously and also mid-flush, clear all words, the registered read addresses, and the counter, and set the state to IDLE.
REQ-034 Under reset, ReadData SHALL be 0, WriteGnt SHALL follow WriteEnable, FlushBusy SHALL be 0 and FlushDone SHALL be 0.

Structure
REQ-035 Package register_file_pkg SHALL hold the flush FSM state enum (IDLE, FLUSH) and a log2-helper constant function.
REQ-036 Sub-module register_file_flush_ctrl SHALL contain the FSM, counter, FlushBusy/FlushDone and the per-group clear strobes; the array, read and write logic SHALL stay in the top level.

Verification
REQ-037 Write port0 addr 3 data 0xA5A5A5A5 BE 0xF; cycle after: read addr 3 -> ReadData 0xA5A5A5A5 one cycle after ReadEnable.
REQ-038 Same cycle port0 addr 7 BE 0x3 data 0x11111111 and port1 addr 7 BE 0xE data 0x22222222 -> word 7 = 0x22221111.
REQ-039 Fill all 32 words with nonzero data, pulse FlushReq -> FlushBusy high for 8 cycles, WriteGnt 0 while busy, FlushDone pulse once, all words read 0.
REQ-040 Hold read addr 31 during flush -> data stays unchanged until the last flush cycle and reads 0 after it; FlushReq re-pulsed mid-flush -> no extension.
REQ-041 Assert rst_n=0 mid-flush (counter=3) -> FlushBusy 0 immediately, all reads 0; after release a write to addr 0 is granted.
REQ-042 FlushReq and WriteEnable port0 addr 2 in the same cycle -> write granted, then word 2 cleared by the flush (reads 0 after FlushDone).
